// File: rtl/vigna_axil_ram.sv
// vigna_axil_ram: AXI4-Lite word-addressed RAM with independent read and write paths.
// Define VIGNA_AXIL_RAM_ERR_EN to answer out-of-range addresses with SLVERR instead of wrapping.
module vigna_axil_ram #(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic [2:0]  s_awprot,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    input  logic [2:0]  s_arprot,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0] r_mem [MEM_WORDS];
    logic        r_aw_full;
    logic [31:0] r_aw_addr;
    logic        r_w_full;
    logic [31:0] r_w_data;
    logic [3:0]  r_w_strb;

    logic [31:0]   w_aw_off;
    logic [31:0]   w_ar_off;
    logic [AW-1:0] w_aw_idx;
    logic [AW-1:0] w_ar_idx;
    logic          w_aw_ok;
    logic          w_ar_ok;
    logic          w_commit;
    logic          w_ar_hs;
    logic          w_unused;

    assign w_aw_off = r_aw_addr - BASE_ADDR;
    assign w_ar_off = s_araddr - BASE_ADDR;
    assign w_aw_idx = w_aw_off[AW+1:2];
    assign w_ar_idx = w_ar_off[AW+1:2];
`ifdef VIGNA_AXIL_RAM_ERR_EN
    assign w_aw_ok = (w_aw_off[31:AW+2] == '0);
    assign w_ar_ok = (w_ar_off[31:AW+2] == '0);
`else
    assign w_aw_ok = 1'b1;
    assign w_ar_ok = 1'b1;
`endif
    assign w_unused = ^{s_awprot, s_arprot, w_aw_off[31:AW+2], w_ar_off[31:AW+2], w_aw_off[1:0], w_ar_off[1:0]};

    assign s_awready = resetn && !r_aw_full;
    assign s_wready  = resetn && !r_w_full;
    assign s_arready = resetn && !s_rvalid;
    // Gating on resetn keeps a reset edge from committing a half-held write.
    assign w_commit  = resetn && r_aw_full && r_w_full && !s_bvalid;
    assign w_ar_hs   = s_arvalid && s_arready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bresp   <= 2'b00;
        end else if (w_commit) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            s_bvalid  <= 1'b1;
            s_bresp   <= w_aw_ok ? 2'b00 : 2'b10;
        end else begin
            if (s_awvalid && s_awready) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                r_w_full <= 1'b1;
                r_w_data <= s_wdata;
                r_w_strb <= s_wstrb;
            end
            if (s_bvalid && s_bready)
                s_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit && w_aw_ok)
            for (int i = 0; i < 4; i++)
                if (r_w_strb[i])
                    r_mem[w_aw_idx][8*i +: 8] <= r_w_data[8*i +: 8];
    end

    // Nonblocking read of r_mem yields pre-commit data on a same-edge collision.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s_rvalid <= 1'b0;
            s_rdata  <= 32'h0;
            s_rresp  <= 2'b00;
        end else if (w_ar_hs) begin
            s_rvalid <= 1'b1;
            s_rdata  <= w_ar_ok ? r_mem[w_ar_idx] : 32'h0;
            s_rresp  <= w_ar_ok ? 2'b00 : 2'b10;
        end else if (s_rvalid && s_rready) begin
            s_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vigna_axil_ram.sv
// tb_vigna_axil_ram: directed scoreboard bench for vigna_axil_ram with a 16-word RAM.
module tb_vigna_axil_ram;
    logic        clk = 1'b0;
    logic        resetn;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic [2:0]  s_awprot, s_arprot;
    logic [1:0]  s_bresp, s_rresp;

    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] m_mem [16];
    logic [1:0]  bq [$];
    logic [33:0] rq [$];
    logic [33:0] e;

    vigna_axil_ram #(.MEM_WORDS(16), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .resetn(resetn),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return a < 32'h40;
    endfunction

    function automatic logic [1:0] wr_resp(input logic [31:0] a);
`ifdef VIGNA_AXIL_RAM_ERR_EN
        if (!in_rng(a)) return 2'b10;
`endif
        return 2'b00;
    endfunction

    function automatic logic [33:0] rd_exp(input logic [31:0] a);
`ifdef VIGNA_AXIL_RAM_ERR_EN
        if (!in_rng(a)) return {2'b10, 32'h0};
`endif
        return {2'b00, m_mem[a[5:2]]};
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v;
        if (wr_resp(a) != 2'b00) return;
        v = m_mem[a[5:2]];
        for (int i = 0; i < 4; i++)
            if (s[i]) v[8*i +: 8] = d[8*i +: 8];
        m_mem[a[5:2]] = v;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic aw_hs, w_hs, aw_done, w_done;
        int lat;
        bq.push_back(wr_resp(a));
        mdl_write(a, d, s);
        aw_done = 0;
        w_done = 0;
        s_bready = 1;
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        s_awvalid = 1; s_wvalid = 1;
        for (int k = 0; k < 20 && !(aw_done && w_done); k++) begin
            aw_hs = s_awvalid && s_awready;
            w_hs = s_wvalid && s_wready;
            tick();
            if (aw_hs) begin s_awvalid = 0; aw_done = 1; end
            if (w_hs) begin s_wvalid = 0; w_done = 1; end
        end
        s_awvalid = 0; s_wvalid = 0;
        lat = 0;
        while (!s_bvalid && lat < 20) begin tick(); lat++; end
        chk("b_latency", lat, 1);
        chk("bresp", {30'h0, s_bresp}, {30'h0, bq.pop_front()});
        tick();
        chk("b_clear", {31'h0, s_bvalid}, 0);
    endtask

    task automatic do_read(input logic [31:0] a);
        logic hs, done;
        rq.push_back(rd_exp(a));
        done = 0;
        s_rready = 1;
        s_araddr = a;
        s_arvalid = 1;
        for (int k = 0; k < 20 && !done; k++) begin
            hs = s_arvalid && s_arready;
            tick();
            if (hs) begin s_arvalid = 0; done = 1; end
        end
        s_arvalid = 0;
        chk("r_valid", {31'h0, s_rvalid}, 1);
        e = rq.pop_front();
        chk("rdata", s_rdata, e[31:0]);
        chk("rresp", {30'h0, s_rresp}, {30'h0, e[33:32]});
        tick();
        chk("r_clear", {31'h0, s_rvalid}, 0);
    endtask

    initial begin
        resetn = 0;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 1; s_rready = 1;
        s_awaddr = 0; s_wdata = 0; s_wstrb = 0; s_araddr = 0; s_awprot = 0; s_arprot = 0;
        tick(); tick();
        chk("rst_awready_low", {31'h0, s_awready}, 0);
        chk("rst_wready_low", {31'h0, s_wready}, 0);
        chk("rst_arready_low", {31'h0, s_arready}, 0);
        resetn = 1;
        tick();
        chk("rst_bvalid", {31'h0, s_bvalid}, 0);
        chk("rst_rvalid", {31'h0, s_rvalid}, 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_resp", {28'h0, s_bresp, s_rresp}, 0);
        chk("rst_readies", {29'h0, s_awready, s_wready, s_arready}, 32'h7);

        do_write(32'h10, 32'hDEADBEEF, 4'hF);
        do_read(32'h10);
        chk("full_word_const", s_rdata, 32'hDEADBEEF);

        do_write(32'h20, 32'hAAAAAAAA, 4'hF);
        do_write(32'h20, 32'h11223344, 4'h5);
        do_read(32'h20);
        chk("strobe_const", s_rdata, 32'hAA22AA44);
        do_write(32'h20, 32'hFFFFFFFF, 4'h0);
        do_read(32'h20);

        // W three cycles ahead of AW, response held off while a second write queues behind it
        s_bready = 0;
        bq.push_back(wr_resp(32'h24));
        mdl_write(32'h24, 32'h55667788, 4'hF);
        s_wdata = 32'h55667788; s_wstrb = 4'hF; s_wvalid = 1;
        chk("w_first_ready", {31'h0, s_wready}, 1);
        tick();
        s_wvalid = 0;
        chk("wready_after_w", {31'h0, s_wready}, 0);
        tick(); tick();
        chk("wready_hold", {31'h0, s_wready}, 0);
        chk("no_commit_wo_aw", {31'h0, s_bvalid}, 0);
        s_awaddr = 32'h24; s_awvalid = 1;
        chk("aw_late_ready", {31'h0, s_awready}, 1);
        tick();
        s_awvalid = 0;
        chk("bvalid_at_aw_hs", {31'h0, s_bvalid}, 0);
        tick();
        chk("bvalid_after_commit", {31'h0, s_bvalid}, 1);
        bq.push_back(wr_resp(32'h28));
        mdl_write(32'h28, 32'hCAFEF00D, 4'hF);
        s_awaddr = 32'h28; s_wdata = 32'hCAFEF00D; s_awvalid = 1; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_bvalid", {31'h0, s_bvalid}, 1);
            chk("bp_readies", {30'h0, s_awready, s_wready}, 0);
            tick();
        end
        chk("bp_bresp", {30'h0, s_bresp}, {30'h0, bq.pop_front()});
        s_bready = 1;
        tick();
        chk("b_hs_clear", {31'h0, s_bvalid}, 0);
        tick();
        chk("second_commit", {31'h0, s_bvalid}, 1);
        chk("second_bresp", {30'h0, s_bresp}, {30'h0, bq.pop_front()});
        tick();
        do_read(32'h24);
        do_read(32'h28);

        // R backpressure with a second AR waiting
        s_rready = 0;
        rq.push_back(rd_exp(32'h10));
        s_araddr = 32'h10; s_arvalid = 1;
        chk("ar_ready_idle", {31'h0, s_arready}, 1);
        tick();
        rq.push_back(rd_exp(32'h20));
        s_araddr = 32'h20;
        e = rq.pop_front();
        for (int i = 0; i < 5; i++) begin
            chk("rbp_rvalid", {31'h0, s_rvalid}, 1);
            chk("rbp_rdata", s_rdata, e[31:0]);
            chk("rbp_arready", {31'h0, s_arready}, 0);
            tick();
        end
        s_rready = 1;
        tick();
        chk("r_hs_clear", {31'h0, s_rvalid}, 0);
        chk("ar_ready_again", {31'h0, s_arready}, 1);
        tick();
        s_arvalid = 0;
        e = rq.pop_front();
        chk("second_ar_rvalid", {31'h0, s_rvalid}, 1);
        chk("second_ar_rdata", s_rdata, e[31:0]);
        tick();

        // read and write commit to word 3 on the same edge
        do_write(32'h0C, 32'h01010101, 4'hF);
        rq.push_back(rd_exp(32'h0C));
        bq.push_back(wr_resp(32'h0C));
        mdl_write(32'h0C, 32'h02020202, 4'hF);
        s_awaddr = 32'h0C; s_wdata = 32'h02020202; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        s_araddr = 32'h0C; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        e = rq.pop_front();
        chk("coll_rvalid", {31'h0, s_rvalid}, 1);
        chk("coll_old", s_rdata, e[31:0]);
        chk("coll_bvalid", {31'h0, s_bvalid}, 1);
        chk("coll_bresp", {30'h0, s_bresp}, {30'h0, bq.pop_front()});
        tick();
        do_read(32'h0C);
        chk("coll_new_const", s_rdata, 32'h02020202);

        do_write(32'h00, 32'h12345678, 4'hF);
        do_write(32'h40, 32'h99999999, 4'hF);
        do_read(32'h00);
        do_read(32'h40);

        // reset while a response is pending
        s_bready = 0;
        mdl_write(32'h08, 32'h0BADF00D, 4'hF);
        s_awaddr = 32'h08; s_wdata = 32'h0BADF00D; s_awvalid = 1; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        tick();
        chk("pre_rst_bvalid", {31'h0, s_bvalid}, 1);
        resetn = 0;
        #1;
        chk("rst_forces_ready", {29'h0, s_awready, s_wready, s_arready}, 0);
        tick();
        chk("rst_clears_bvalid", {31'h0, s_bvalid}, 0);
        resetn = 1;
        s_bready = 1;
        tick();
        chk("post_rst_readies", {29'h0, s_awready, s_wready, s_arready}, 32'h7);

        s_wdata = 32'hBAD0BAD0; s_wvalid = 1;
        tick();
        s_wvalid = 0;
        chk("held_w_full", {31'h0, s_wready}, 0);
        resetn = 0;
        tick();
        resetn = 1;
        tick();
        chk("held_w_dropped", {31'h0, s_wready}, 1);
        do_read(32'h08);

        chk("bq_empty", bq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
